spi_cmd_ctrl: RTL and testbench

System-clock-side command controller for spi_slave. It turns the received SPI byte stream into memory/register bus transactions: command byte, address byte, then a data burst. Write frames push data bytes into the 8-bit computer memory bus. Read frames fetch bytes and present them on spi_txdata for shifting out. It also handles the spi_sck to clk crossing of the frame and byte strobes.

---
 rtl/spi_cmd_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: turns the SPI byte stream (command, address, data burst) into
// 8-bit memory bus transactions and presents read data back for shift-out.
module spi_cmd_ctrl #(
   parameter int unsigned PARA_DATA_WIDTH = 8,
   parameter int unsigned PARA_ADDR_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       sync_rst,
   input  logic                       spi_cs_n,
   input  logic [PARA_DATA_WIDTH-1:0] spi_rxdata,
   input  logic                       spi_rxdata_valid,
   output logic [PARA_DATA_WIDTH-1:0] spi_txdata,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [PARA_ADDR_WIDTH-1:0] mem_addr,
   output logic [PARA_DATA_WIDTH-1:0] mem_wdata,
   input  logic [PARA_DATA_WIDTH-1:0] mem_rdata,
   input  logic                       mem_ack,
   output logic                       frame_active,
   output logic                       ovr_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_WR_DATA, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_RD_DATA
   } state_t;

   state_t                     r_state, w_state;
   logic                       r_cs_s1, r_cs_s2, r_cs_s3;
   logic                       r_vld_s1, r_vld_s2, r_vld_s3;
   logic                       r_wr, w_wr;
   logic                       r_ainc, w_ainc;
   logic                       r_end_pend, w_end_pend;
   logic                       r_start_pend, w_start_pend;
   logic [PARA_DATA_WIDTH-1:0] r_txdata, w_txdata;
   logic                       r_mem_req, w_mem_req;
   logic                       r_mem_we, w_mem_we;
   logic [PARA_ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
   logic [PARA_DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata;
   logic                       r_frame_active, w_frame_active;
   logic                       r_ovr_err, w_ovr_err;
   logic                       w_byte_evt, w_frame_start, w_frame_end;
   logic [PARA_ADDR_WIDTH-1:0] w_addr_inc;

   // Edge events from the synchronized chip select and byte-valid strobes
   assign w_byte_evt    = r_vld_s2 & ~r_vld_s3;
   assign w_frame_start = r_cs_s3 & ~r_cs_s2;
   assign w_frame_end   = ~r_cs_s3 & r_cs_s2;
   assign w_addr_inc    = r_mem_addr + PARA_ADDR_WIDTH'(r_ainc);

   // Next-state, datapath and frame boundary handling
   always_comb begin
      w_state        = r_state;
      w_wr           = r_wr;
      w_ainc         = r_ainc;
      w_end_pend     = r_end_pend;
      w_start_pend   = r_start_pend;
      w_txdata       = r_txdata;
      w_mem_req      = r_mem_req;
      w_mem_we       = r_mem_we;
      w_mem_addr     = r_mem_addr;
      w_mem_wdata    = r_mem_wdata;
      w_ovr_err      = r_ovr_err;
      w_frame_active = r_frame_active;

      if (w_frame_start) w_frame_active = 1'b1;
      if (w_frame_end)   w_frame_active = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_frame_start) begin
               w_state   = S_CMD;
               w_ovr_err = 1'b0;
            end
         end
         S_CMD: begin
            if (w_byte_evt) begin
               w_wr    = spi_rxdata[7];
               w_ainc  = spi_rxdata[6];
               w_state = S_ADDR;
            end
         end
         S_ADDR: begin
            if (w_byte_evt) begin
               w_mem_addr = PARA_ADDR_WIDTH'(spi_rxdata);
               w_state    = r_wr ? S_WR_DATA : S_RD_REQ;
            end
         end
         S_WR_DATA: begin
            if (w_byte_evt) begin
               w_mem_wdata = spi_rxdata;
               w_mem_req   = 1'b1;
               w_mem_we    = 1'b1;
               w_state     = S_WR_WAIT;
            end
         end
         S_WR_WAIT: begin
            if (w_byte_evt) w_ovr_err = 1'b1;
            if (mem_ack) begin
               w_mem_req  = 1'b0;
               w_mem_addr = w_addr_inc;
               w_state    = S_WR_DATA;
            end
         end
         S_RD_REQ: begin
            if (w_byte_evt) w_ovr_err = 1'b1;
            w_mem_req = 1'b1;
            w_mem_we  = 1'b0;
            w_state   = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (w_byte_evt) w_ovr_err = 1'b1;
            if (mem_ack) begin
               w_txdata   = mem_rdata;
               w_mem_req  = 1'b0;
               w_mem_addr = w_addr_inc;
               w_state    = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (w_byte_evt) w_state = S_RD_REQ;
         end
         default: w_state = S_IDLE;
      endcase

      // Frame end: finish any outstanding request, then leave the frame
      if (r_state != S_IDLE && (w_frame_end || r_end_pend)) begin
         if (w_mem_req) begin
            w_end_pend = 1'b1;
            if (w_frame_start) w_start_pend = 1'b1;
         end else begin
            w_end_pend = 1'b0;
            w_txdata   = '0;
            if (r_start_pend || w_frame_start) begin
               w_state      = S_CMD;
               w_ovr_err    = 1'b0;
               w_start_pend = 1'b0;
            end else begin
               w_state = S_IDLE;
            end
         end
      end
   end

   // State, synchronizers and registered outputs
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         r_state        <= S_IDLE;
         r_cs_s1        <= 1'b0;
         r_cs_s2        <= 1'b0;
         r_cs_s3        <= 1'b0;
         r_vld_s1       <= 1'b0;
         r_vld_s2       <= 1'b0;
         r_vld_s3       <= 1'b0;
         r_wr           <= 1'b0;
         r_ainc         <= 1'b0;
         r_end_pend     <= 1'b0;
         r_start_pend   <= 1'b0;
         r_txdata       <= '0;
         r_mem_req      <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
         r_frame_active <= 1'b0;
         r_ovr_err      <= 1'b0;
      end else begin
         r_state        <= w_state;
         r_cs_s1        <= spi_cs_n;
         r_cs_s2        <= r_cs_s1;
         r_cs_s3        <= r_cs_s2;
         r_vld_s1       <= spi_rxdata_valid;
         r_vld_s2       <= r_vld_s1;
         r_vld_s3       <= r_vld_s2;
         r_wr           <= w_wr;
         r_ainc         <= w_ainc;
         r_end_pend     <= w_end_pend;
         r_start_pend   <= w_start_pend;
         r_txdata       <= w_txdata;
         r_mem_req      <= w_mem_req;
         r_mem_we       <= w_mem_we;
         r_mem_addr     <= w_mem_addr;
         r_mem_wdata    <= w_mem_wdata;
         r_frame_active <= w_frame_active;
         r_ovr_err      <= w_ovr_err;
      end
   end

   assign spi_txdata   = r_txdata;
   assign mem_req      = r_mem_req;
   assign mem_we       = r_mem_we;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign frame_active = r_frame_active;
   assign ovr_err      = r_ovr_err;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: SPI frames are driven at byte level, a bus memory
// responds with random latency, and a frame-level model predicts the bus
// transactions, MISO slot bytes, final address and overrun flag.
module tb_spi_cmd_ctrl;

   logic       clk = 1'b0;
   logic       sync_rst;
   logic       spi_cs_n;
   logic [7:0] spi_rxdata;
   logic       spi_rxdata_valid;
   logic [7:0] spi_txdata;
   logic       mem_req;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       mem_ack;
   logic       frame_active;
   logic       ovr_err;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  env_mem [256];
   logic [7:0]  ref_mem [256];
   logic [16:0] act_q [$];
   logic [7:0]  fr_data [8];
   int          slow_lat = 0;

   always #5 clk = ~clk;

   spi_cmd_ctrl #(.PARA_DATA_WIDTH(8), .PARA_ADDR_WIDTH(8)) u_dut (
      .clk              (clk),
      .sync_rst         (sync_rst),
      .spi_cs_n         (spi_cs_n),
      .spi_rxdata       (spi_rxdata),
      .spi_rxdata_valid (spi_rxdata_valid),
      .spi_txdata       (spi_txdata),
      .mem_req          (mem_req),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata),
      .mem_ack          (mem_ack),
      .frame_active     (frame_active),
      .ovr_err          (ovr_err)
   );

   // Single comparison point
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bus memory: acks each request after a latency, logs what it served
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (mem_req && !sync_rst) begin
            int lat;
            lat = (slow_lat > 0) ? slow_lat : int'($urandom_range(0, 3));
            repeat (lat) @(negedge clk);
            if (mem_req) begin
               if (mem_we) begin
                  env_mem[mem_addr] = mem_wdata;
                  act_q.push_back({1'b1, mem_addr, mem_wdata});
               end else begin
                  mem_rdata = env_mem[mem_addr];
                  act_q.push_back({1'b0, mem_addr, env_mem[mem_addr]});
               end
               mem_ack = 1'b1;
               @(negedge clk);
               mem_ack = 1'b0;
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit last);
      spi_rxdata       = b;
      spi_rxdata_valid = 1'b1;
      if (last) spi_cs_n = 1'b1;
      repeat (4) @(negedge clk);
      spi_rxdata_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300 && mem_req; i++) @(negedge clk);
      chk("drain_timeout", 32'(mem_req), 32'd0);
   endtask

   // One frame: cmd, addr, n data/dummy bytes from fr_data; last byte ends the frame
   task automatic do_frame(input logic [7:0] cmd, input logic [7:0] a, input int n, input bit ovr_case);
      logic [7:0]  bytes [$];
      logic [7:0]  exp_tx [$];
      logic [16:0] exp_q [$];
      logic [7:0]  ad, fa;
      int          step, n_eff;
      step = cmd[6] ? 1 : 0;
      bytes = {cmd, a};
      for (int j = 0; j < n; j++) bytes.push_back(fr_data[j]);
      for (int k = 0; k < n + 2; k++) exp_tx.push_back(8'h00);
      if (cmd[7]) begin
         n_eff = ovr_case ? 1 : n;
         for (int j = 0; j < n_eff; j++) begin
            ad = 8'(int'(a) + j * step);
            exp_q.push_back({1'b1, ad, fr_data[j]});
            ref_mem[ad] = fr_data[j];
         end
      end else begin
         n_eff = n;
         for (int j = 0; j < n; j++) begin
            ad = 8'(int'(a) + j * step);
            exp_q.push_back({1'b0, ad, ref_mem[ad]});
            exp_tx[j + 2] = ref_mem[ad];
         end
      end
      fa = 8'(int'(a) + n_eff * step);
      act_q.delete();

      spi_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      chk("frame_active_hi", 32'(frame_active), 32'd1);
      chk("ovr_clr_at_start", 32'(ovr_err), 32'd0);
      for (int k = 0; k < bytes.size(); k++) begin
         repeat (24) @(negedge clk);
         chk($sformatf("miso_slot%0d", k), 32'(spi_txdata), 32'(exp_tx[k]));
         send_byte(bytes[k], k == bytes.size() - 1);
      end
      repeat (20) @(negedge clk);
      wait_drain();
      repeat (4) @(negedge clk);
      chk("txn_count", 32'(act_q.size()), 32'(exp_q.size()));
      for (int j = 0; j < exp_q.size() && j < act_q.size(); j++)
         chk($sformatf("txn%0d_we_addr_data", j), 32'(act_q[j]), 32'(exp_q[j]));
      chk("end_addr", 32'(mem_addr), 32'(fa));
      chk("end_ovr", 32'(ovr_err), 32'(ovr_case));
      chk("end_txdata", 32'(spi_txdata), 32'd0);
      chk("end_frame_active", 32'(frame_active), 32'd0);
      chk("end_req", 32'(mem_req), 32'd0);
   endtask

   initial begin
      sync_rst = 1'b1;
      spi_cs_n = 1'b1;
      spi_rxdata = 8'h00;
      spi_rxdata_valid = 1'b0;
      for (int i = 0; i < 256; i++) begin
         env_mem[i] = 8'($urandom);
         ref_mem[i] = env_mem[i];
      end
      repeat (5) @(negedge clk);
      chk("rst_txdata", 32'(spi_txdata), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_frame_active", 32'(frame_active), 32'd0);
      chk("rst_ovr", 32'(ovr_err), 32'd0);
      sync_rst = 1'b0;
      repeat (10) @(negedge clk);

      // Write burst with auto-increment
      fr_data[0] = 8'hAA; fr_data[1] = 8'hBB; fr_data[2] = 8'hCC;
      do_frame(8'hC0, 8'h10, 3, 1'b0);
      // Preload then read burst
      fr_data[0] = 8'h11; fr_data[1] = 8'h22;
      do_frame(8'hC0, 8'h20, 2, 1'b0);
      fr_data[0] = 8'h00; fr_data[1] = 8'h00;
      do_frame(8'h40, 8'h20, 2, 1'b0);
      // Fixed-address read, three dummies
      fr_data[2] = 8'h00;
      do_frame(8'h00, 8'h05, 3, 1'b0);
      // Address wrap on write
      fr_data[0] = 8'h01; fr_data[1] = 8'h02;
      do_frame(8'hC0, 8'hFF, 2, 1'b0);

      // Overrun: slow ack, second data byte dropped; next frame clears the flag
      slow_lat = 80;
      fr_data[0] = 8'h5A; fr_data[1] = 8'hA5;
      do_frame(8'hC0, 8'h30, 2, 1'b1);
      slow_lat = 0;
      fr_data[0] = 8'h00;
      do_frame(8'h40, 8'h30, 1, 1'b0);

      // Randomized frames
      for (int f = 0; f < 12; f++) begin
         logic [7:0] c, a;
         int n;
         c = 8'($urandom);
         a = 8'($urandom);
         n = int'($urandom_range(1, 4));
         for (int j = 0; j < 8; j++) fr_data[j] = 8'($urandom);
         do_frame(c, a, n, 1'b0);
      end

      // Abort: cs_n rises while a read is pending
      slow_lat = 40;
      act_q.delete();
      spi_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      repeat (24) @(negedge clk);
      send_byte(8'h40, 1'b0);
      repeat (24) @(negedge clk);
      send_byte(8'h20, 1'b0);
      repeat (10) @(negedge clk);
      chk("abort_req_pending", 32'(mem_req), 32'd1);
      spi_cs_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("abort_req_held", 32'(mem_req), 32'd1);
      wait_drain();
      repeat (4) @(negedge clk);
      chk("abort_txn_count", 32'(act_q.size()), 32'd1);
      if (act_q.size() > 0) chk("abort_txn", 32'(act_q[0]), 32'({1'b0, 8'h20, ref_mem[8'h20]}));
      chk("abort_txdata", 32'(spi_txdata), 32'd0);
      chk("abort_frame_active", 32'(frame_active), 32'd0);
      chk("abort_addr", 32'(mem_addr), 32'h21);

      // Reset in the middle of a pending write
      act_q.delete();
      spi_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      repeat (24) @(negedge clk);
      send_byte(8'hC0, 1'b0);
      repeat (24) @(negedge clk);
      send_byte(8'h44, 1'b0);
      repeat (24) @(negedge clk);
      send_byte(8'h99, 1'b0);
      repeat (10) @(negedge clk);
      chk("midrst_req_before", 32'(mem_req), 32'd1);
      sync_rst = 1'b1;
      @(negedge clk);
      chk("midrst_req", 32'(mem_req), 32'd0);
      chk("midrst_addr", 32'(mem_addr), 32'd0);
      chk("midrst_frame_active", 32'(frame_active), 32'd0);
      sync_rst = 1'b0;
      spi_cs_n = 1'b1;
      repeat (60) @(negedge clk);
      chk("midrst_no_txn", 32'(act_q.size()), 32'd0);
      slow_lat = 0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
